ysyx_23060171_exu_mc: RTL
=========================

Name: ysyx_23060171_exu_mc

Overview:
- Parametrised, handshaked successor of the combinational execute stage, sitting between IDU and ISU/LSU.
- Registers its result and sideband in a 1-deep output stage with valid/ready on both sides.
- Resolves jump/branch redirects and supports a flush.
- Optionally contains an iterative multiply/divide unit (RV M-extension semantics) with multi-cycle latency.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- CTRL_W, 24, width of opaque sideband passed unchanged to ISU (rw, crw, mem/reg write controls, irq).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  IDU holds a valid op
- in_ready  out  1  EXU accepts op this cycle
- in_pc  in  XLEN  instruction PC
- in_rs1, in_rs2, in_imm  in  XLEN  operands
- in_op  in  5  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB; 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU
- in_src_a  in  1  0 rs1, 1 pc
- in_src_b  in  1  0 rs2, 1 imm
- in_jump  in  2  0 none, 1 JAL, 2 JALR, 3 BRANCH
- in_bcond  in  3  RV funct3 for BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU)
- in_ctrl  in  CTRL_W  sideband
- in_flush  in  1  kill in-flight and held ops
- out_valid  out  1  result valid
- out_ready  in  1  ISU accepts
- out_result  out  XLEN  ALU/MDU result, or pc+4 for JAL/JALR
- out_redirect  out  1  control transfer taken
- out_target  out  XLEN  redirect target
- out_rs2  out  XLEN  store data
- out_ctrl  out  CTRL_W  sideband
- busy  out  1  MDU iterating

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid=0, busy=0; out_result, out_target, out_rs2, out_ctrl, out_redirect all 0.
- States:
  - IDLE: no op held.
  - MDU: iterating.
  - HOLD: out_valid=1, waiting for out_ready.
- in_ready = !in_flush && state!=MDU && (state==IDLE || out_ready).
- Accept = in_valid && in_ready.
- Single-cycle ops (in_op<16): result registered at accept; out_valid=1 next cycle (latency 1).
  - Back-to-back throughput 1/cycle when out_ready stays high.
- ALU: operands A/B per src muxes; shifts use B[log2(XLEN)-1:0]; SLT signed, SLTU unsigned; PASSB gives B.
- Jumps (result = pc+4):
  - JAL: target pc+imm.
  - JALR: target (rs1+imm) with bit0 cleared.
  - BRANCH: compare rs1 vs rs2 per in_bcond, target pc+imm; out_redirect=taken.
  - Illegal bcond (2,3): not taken.
  - out_redirect=0 for in_jump=0.
- MDU ops: accept moves to MDU; busy=1; shift-add multiply / restoring divide, one bit per cycle.
  - out_valid asserts exactly XLEN+1 cycles after accept.
  - Then HOLD.
- Divide corner cases:
  - Divisor 0: DIV/DIVU quotient all-ones; REM/REMU = dividend.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder 0.
- HOLD: outputs stable until out_ready.
  - out_ready && no new accept -> IDLE.
  - out_ready with simultaneous accept -> load new op (HOLD for ALU, MDU for MDU).
- in_flush (any state): next cycle state IDLE, out_valid=0, busy=0, MDU aborted.
  - Flush wins over simultaneous in_valid and out_ready; the op is not accepted.
- Reset mid-MDU: immediate IDLE, no residual result.

Optional Feature:
- Macro YSYX_23060171_MDU_EN.
- Defined: MDU present as above.
- Undefined: no MDU logic; ops >=16 complete in 1 cycle with out_result=0, out_redirect=0; busy tied 0.

Test Plan:
- XLEN=32, ADD rs1=0x7FFFFFFF, rs2=1, out_ready=1 -> out_valid next cycle, result 0x80000000, redirect 0; 4 back-to-back ops complete in 4 consecutive cycles.
- BLT pc=0x80000010, rs1=0xFFFFFFFF, rs2=1, imm=0xFFFFFFF0 -> redirect=1, target 0x80000000; BLTU same operands -> redirect=0.
- JALR rs1=0x80000003, imm=4 -> target 0x80000006, result pc+4.
- MDU_EN: DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000 after 33 cycles, in_ready=0 throughout; DIVU x/0 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0; release with in_valid=1 -> swap in the same cycle.
- in_flush at cycle 10 of MUL -> out_valid and busy 0 next cycle, no result emitted; rst_n low mid-op -> all outputs 0 immediately.

Source files
------------

// File: rtl/ysyx_23060171_exu_mc.sv
// Handshaked execute stage: ALU, jump/branch resolution and a 1-deep registered output stage.
// Define YSYX_23060171_MDU_EN to build in the iterative multiply/divide unit (RV M semantics).
module ysyx_23060171_exu_mc #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [4:0]        in_op,
    input  logic              in_src_a,
    input  logic              in_src_b,
    input  logic [1:0]        in_jump,
    input  logic [2:0]        in_bcond,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic              out_redirect,
    output logic [XLEN-1:0]   out_target,
    output logic [XLEN-1:0]   out_rs2,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              busy
);
    localparam int unsigned SHW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MDU, S_HOLD} state_t;
    state_t state;

    logic            accept;
    logic            is_mdu;
    logic [XLEN-1:0] opa, opb;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res, single_res, target_c;
    logic            taken, redirect_c;

    assign in_ready  = !in_flush && (state != S_MDU) && (state == S_IDLE || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_HOLD);
    assign busy      = (state == S_MDU);

    assign opa   = in_src_a ? in_pc : in_rs1;
    assign opb   = in_src_b ? in_imm : in_rs2;
    assign shamt = opb[SHW-1:0];

    // Single-cycle ALU; codes above PASSB produce 0
    always_comb begin
        alu_res = '0;
        case (in_op)
            5'd0:    alu_res = opa + opb;
            5'd1:    alu_res = opa - opb;
            5'd2:    alu_res = opa << shamt;
            5'd3:    alu_res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
            5'd4:    alu_res = {{(XLEN-1){1'b0}}, (opa < opb)};
            5'd5:    alu_res = opa ^ opb;
            5'd6:    alu_res = opa >> shamt;
            5'd7:    alu_res = XLEN'($signed(opa) >>> shamt);
            5'd8:    alu_res = opa | opb;
            5'd9:    alu_res = opa & opb;
            5'd10:   alu_res = opb;
            default: alu_res = '0;
        endcase
    end

    // Branch condition and redirect resolution
    always_comb begin
        taken = 1'b0;
        case (in_bcond)
            3'd0:    taken = (in_rs1 == in_rs2);
            3'd1:    taken = (in_rs1 != in_rs2);
            3'd4:    taken = ($signed(in_rs1) < $signed(in_rs2));
            3'd5:    taken = !($signed(in_rs1) < $signed(in_rs2));
            3'd6:    taken = (in_rs1 < in_rs2);
            3'd7:    taken = !(in_rs1 < in_rs2);
            default: taken = 1'b0;
        endcase
        redirect_c = 1'b0;
        case (in_jump)
            2'd1, 2'd2: redirect_c = !in_op[4];
            2'd3:       redirect_c = !in_op[4] && taken;
            default:    redirect_c = 1'b0;
        endcase
        target_c   = (in_jump == 2'd2) ? ((in_rs1 + in_imm) & ~XLEN'(1)) : (in_pc + in_imm);
        single_res = in_op[4] ? '0 : ((in_jump != 2'd0) ? (in_pc + XLEN'(4)) : alu_res);
    end

`ifdef YSYX_23060171_MDU_EN
    localparam int unsigned PW = 2 * XLEN;

    logic            md_div, md_hi, md_neg, md_zero;
    logic [SHW-1:0]  md_cnt;
    logic [PW-1:0]   md_acc, md_mcand;
    logic [XLEN-1:0] md_mplier, md_rem, md_quo, md_dvsr;

    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [PW-1:0]   acc_nx, prod;
    logic [XLEN:0]   r_sh, diff;
    logic [XLEN-1:0] rem_nx, quo_nx, quo_f, rem_f, mdu_res;

    // Work on magnitudes; the sign is reapplied once iteration completes
    assign is_mdu = (in_op[4:3] == 2'b10);
    assign a_sgn  = in_op[2] ? !in_op[0] : (in_op[1:0] == 2'b01 || in_op[1:0] == 2'b10);
    assign b_sgn  = in_op[2] ? !in_op[0] : (in_op[1:0] == 2'b01);
    assign a_neg  = a_sgn && opa[XLEN-1];
    assign b_neg  = b_sgn && opb[XLEN-1];
    assign a_mag  = a_neg ? -opa : opa;
    assign b_mag  = b_neg ? -opb : opb;

    // One shift-add and one restoring-divide step per cycle
    assign acc_nx  = md_acc + (md_mplier[0] ? md_mcand : PW'(0));
    assign r_sh    = {md_rem, md_quo[XLEN-1]};
    assign diff    = r_sh - {1'b0, md_dvsr};
    assign rem_nx  = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_nx  = {md_quo[XLEN-2:0], !diff[XLEN]};
    assign prod    = md_neg ? -acc_nx : acc_nx;
    assign quo_f   = md_zero ? '1 : (md_neg ? -quo_nx : quo_nx);
    assign rem_f   = md_neg ? -rem_nx : rem_nx;
    assign mdu_res = md_div ? (md_hi ? rem_f : quo_f)
                            : (md_hi ? prod[PW-1:XLEN] : prod[XLEN-1:0]);
`else
    assign is_mdu = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            out_result   <= '0;
            out_redirect <= 1'b0;
            out_target   <= '0;
            out_rs2      <= '0;
            out_ctrl     <= '0;
`ifdef YSYX_23060171_MDU_EN
            md_div    <= 1'b0;
            md_hi     <= 1'b0;
            md_neg    <= 1'b0;
            md_zero   <= 1'b0;
            md_cnt    <= '0;
            md_acc    <= '0;
            md_mcand  <= '0;
            md_mplier <= '0;
            md_rem    <= '0;
            md_quo    <= '0;
            md_dvsr   <= '0;
`endif
        end else if (in_flush) begin
            state <= S_IDLE;
        end else if (accept) begin
            out_rs2    <= in_rs2;
            out_ctrl   <= in_ctrl;
            out_target <= target_c;
            if (is_mdu) begin
                state        <= S_MDU;
                out_redirect <= 1'b0;
`ifdef YSYX_23060171_MDU_EN
                md_div    <= in_op[2];
                md_hi     <= in_op[2] ? in_op[1] : (in_op[1:0] != 2'b00);
                md_neg    <= (in_op[2] && in_op[1]) ? a_neg : (a_neg ^ b_neg);
                md_zero   <= (opb == '0);
                md_cnt    <= '0;
                md_acc    <= '0;
                md_mcand  <= PW'(a_mag);
                md_mplier <= b_mag;
                md_rem    <= '0;
                md_quo    <= a_mag;
                md_dvsr   <= b_mag;
`endif
            end else begin
                state        <= S_HOLD;
                out_result   <= single_res;
                out_redirect <= redirect_c;
            end
        end else begin
            case (state)
                S_HOLD: if (out_ready) state <= S_IDLE;
`ifdef YSYX_23060171_MDU_EN
                S_MDU: begin
                    md_acc    <= acc_nx;
                    md_mcand  <= md_mcand << 1;
                    md_mplier <= md_mplier >> 1;
                    md_rem    <= rem_nx;
                    md_quo    <= quo_nx;
                    md_cnt    <= md_cnt + SHW'(1);
                    if (md_cnt == SHW'(XLEN - 1)) begin
                        state      <= S_HOLD;
                        out_result <= mdu_res;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
